// File: rtl/ms_uart_tx_engine.sv
// UART transmit engine: pops words from the TX FIFO and serialises them onto TXD
// using a per-frame latched baud divisor, optional parity and 1 or 2 stop bits.
module ms_uart_tx_engine #(
  parameter int DWIDTH = 8,
  parameter int DIVW   = 16
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ENABLE,
  input  logic [DIVW-1:0]   BAUD_DIV,
  input  logic              PARITY_EN,
  input  logic              PARITY_ODD,
  input  logic              STOP2,
  input  logic              FIFO_EMPTY,
  input  logic [DWIDTH-1:0] FIFO_DOUT,
  output logic              FIFO_RD,
  output logic              TXD,
  output logic              BUSY,
  output logic              TX_DONE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  localparam int BCW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DWIDTH - 1);

  logic [2:0]        r_state;
  logic              r_txd;
  logic              r_fifo_rd;
  logic              r_tx_done;
  logic [DIVW-1:0]   r_baud_cnt;
  logic [DIVW-1:0]   r_reload;
  logic [BCW-1:0]    r_bit_cnt;
  logic [DWIDTH-1:0] r_shift;
  logic              r_parity;
  logic              r_par_en;
  logic              r_stop2;

  logic [DIVW-1:0]   w_div_m1;
  logic              w_baud_end;
  logic              w_fetch;
  logic [DWIDTH-1:0] w_shift_nxt;

  // A divisor of 0 behaves like 1, so the reload value saturates at 0.
  assign w_div_m1    = (BAUD_DIV == '0) ? '0 : BAUD_DIV - DIVW'(1);
  assign w_baud_end  = (r_baud_cnt == '0);
  assign w_fetch     = ENABLE && !FIFO_EMPTY;
  assign w_shift_nxt = r_shift >> 1;

  assign FIFO_RD = r_fifo_rd;
  assign TXD     = r_txd;
  assign BUSY    = (r_state != S_IDLE);
  assign TX_DONE = r_tx_done;

  // TXD is registered alongside the state so the pin never glitches.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_fifo_rd  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_baud_cnt <= '0;
      r_reload   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_fifo_rd <= 1'b0;
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_fetch) begin
            r_state   <= S_FETCH;
            r_fifo_rd <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift    <= FIFO_DOUT;
          r_reload   <= w_div_m1;
          r_baud_cnt <= w_div_m1;
          r_par_en   <= PARITY_EN;
          r_stop2    <= STOP2;
          r_parity   <= (^FIFO_DOUT) ^ PARITY_ODD;
          r_bit_cnt  <= '0;
          r_txd      <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud_cnt <= r_reload;
            r_bit_cnt  <= '0;
            r_txd      <= r_shift[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt - DIVW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= r_reload;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_txd   <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              r_shift   <= w_shift_nxt;
              r_txd     <= w_shift_nxt[0];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - DIVW'(1);
          end
        end
        S_PARITY: begin
          if (w_baud_end) begin
            r_baud_cnt <= r_reload;
            r_bit_cnt  <= '0;
            r_txd      <= 1'b1;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt - DIVW'(1);
          end
        end
        S_STOP: begin
          r_txd <= 1'b1;
          // r_bit_cnt counts completed stop bits when two are requested.
          if (w_baud_end) begin
            if (r_stop2 && (r_bit_cnt == '0)) begin
              r_bit_cnt  <= BCW'(1);
              r_baud_cnt <= r_reload;
            end else begin
              r_bit_cnt <= '0;
              r_tx_done <= 1'b1;
              if (w_fetch) begin
                r_state   <= S_FETCH;
                r_fifo_rd <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - DIVW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_uart_tx_engine.sv
// Self-checking bench for ms_uart_tx_engine: a small FIFO model feeds words and
// each captured TXD frame is compared with a bit-level expectation.
module tb_ms_uart_tx_engine;
  localparam int DWIDTH = 8;
  localparam int DIVW   = 16;

  logic              clk = 1'b0;
  logic              resetN;
  logic              enable;
  logic [DIVW-1:0]   baudDiv;
  logic              parityEn;
  logic              parityOdd;
  logic              stop2;
  logic              fifoEmpty;
  logic [DWIDTH-1:0] fifoDout;
  logic              fifoRd;
  logic              txd;
  logic              busy;
  logic              txDone;

  ms_uart_tx_engine #(.DWIDTH(DWIDTH), .DIVW(DIVW)) dut (
    .CLK        (clk),
    .RESETN     (resetN),
    .ENABLE     (enable),
    .BAUD_DIV   (baudDiv),
    .PARITY_EN  (parityEn),
    .PARITY_ODD (parityOdd),
    .STOP2      (stop2),
    .FIFO_EMPTY (fifoEmpty),
    .FIFO_DOUT  (fifoDout),
    .FIFO_RD    (fifoRd),
    .TXD        (txd),
    .BUSY       (busy),
    .TX_DONE    (txDone)
  );

  always #5 clk = ~clk;

  logic [7:0] fifoMem [0:31];
  logic [4:0] wrPtr = '0;
  logic [4:0] rdPtr = '0;
  int cyc = 0;
  int rdCount = 0;
  int doneCount = 0;
  int rdWhileEmpty = 0;
  int testCount = 0;
  int failCount = 0;

  assign fifoEmpty = (wrPtr == rdPtr);

  // FIFO read side: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txDone) doneCount <= doneCount + 1;
    if (fifoRd) begin
      rdCount <= rdCount + 1;
      if (fifoEmpty) begin
        rdWhileEmpty <= rdWhileEmpty + 1;
      end else begin
        fifoDout <= fifoMem[rdPtr];
        rdPtr    <= rdPtr + 5'd1;
      end
    end
  end

  typedef struct {
    int         div;
    int         effDiv;
    bit         parEn;
    bit         parOdd;
    bit         stopTwo;
    logic [7:0] word;
    int         expLen;
    bit         expPar;
  } vecT;

  vecT vecs [0:6];

  bit trace [0:1023];
  int traceLen;
  int fallCyc;
  int doneCyc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [7:0] w);
    fifoMem[wrPtr] = w;
    wrPtr = wrPtr + 5'd1;
  endtask

  task automatic applyStimulus(input vecT v);
    baudDiv   = DIVW'(v.div);
    parityEn  = v.parEn;
    parityOdd = v.parOdd;
    stop2     = v.stopTwo;
    pushWord(v.word);
  endtask

  task automatic waitFall(output bit ok);
    int waitCnt;
    waitCnt = 0;
    do begin
      @(negedge clk);
      waitCnt++;
    end while (txd !== 1'b0 && waitCnt < 400);
    ok = (txd === 1'b0);
    if (!ok) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL start_bit_timeout: got txd=%b, expected 0 within 400 cycles", txd);
    end
    fallCyc = cyc;
  endtask

  // Records TXD from the falling start edge up to (not including) the TX_DONE cycle.
  task automatic traceFrame(input int changeAt, input int newDiv, output bit ok);
    waitFall(ok);
    traceLen = 0;
    if (!ok) return;
    trace[0] = 1'b0;
    traceLen = 1;
    forever begin
      @(negedge clk);
      if (traceLen == changeAt) baudDiv = DIVW'(newDiv);
      if (txDone === 1'b1) break;
      if (traceLen >= 1000) begin
        ok = 0;
        testCount++;
        failCount++;
        $display("[TB] FAIL tx_done_timeout: got no TX_DONE, expected one within 1000 cycles");
        break;
      end
      trace[traceLen] = txd;
      traceLen++;
    end
    doneCyc = cyc;
  endtask

  function automatic bit expBit(input int c, input int effDiv, input logic [7:0] word,
                                input bit parEn, input bit expPar);
    int k;
    k = c / effDiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return word[k-1];
    if (parEn && k == 9) return expPar;
    return 1'b1;
  endfunction

  task automatic checkFrame(input string name, input int effDiv, input logic [7:0] word,
                            input bit parEn, input bit expPar, input int expLen);
    int firstBad;
    firstBad = -1;
    for (int c = 0; c < traceLen; c++) begin
      if (trace[c] !== expBit(c, effDiv, word, parEn, expPar) && firstBad < 0) firstBad = c;
    end
    checkOutput({name, "_length"}, traceLen, expLen);
    checkOutput({name, "_first_bad_bit_cycle"}, firstBad, -1);
    if (parEn && traceLen > 9 * effDiv) begin
      checkOutput({name, "_parity_bit"}, int'(trace[9 * effDiv]), int'(expPar));
    end
  endtask

  initial begin
    bit ok;
    int rd0;
    int done0;
    int bad;
    int prevDone;

    //            div effDiv par odd st2 word   len par
    vecs[0] = '{4, 4, 1'b0, 1'b0, 1'b0, 8'h55, 40, 1'b0};
    vecs[1] = '{2, 2, 1'b1, 1'b0, 1'b1, 8'h07, 24, 1'b1};
    vecs[2] = '{2, 2, 1'b1, 1'b1, 1'b1, 8'h07, 24, 1'b0};
    vecs[3] = '{2, 2, 1'b1, 1'b0, 1'b0, 8'h07, 22, 1'b1};
    vecs[4] = '{0, 1, 1'b0, 1'b0, 1'b0, 8'h3C, 10, 1'b0};
    vecs[5] = '{1, 1, 1'b1, 1'b1, 1'b0, 8'hA5, 11, 1'b1};
    vecs[6] = '{3, 3, 1'b0, 1'b0, 1'b1, 8'h81, 33, 1'b0};

    resetN = 1'b0; enable = 1'b0; baudDiv = DIVW'(4);
    parityEn = 1'b0; parityOdd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", int'(txd), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_fifo_rd", int'(fifoRd), 0);
    checkOutput("reset_tx_done", int'(txDone), 0);
    resetN = 1'b1;
    enable = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifoRd !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("empty_idle_violations", bad, 0);
    checkOutput("empty_idle_pops", rdCount, 0);

    for (int i = 0; i < 7; i++) begin
      rd0 = rdCount;
      done0 = doneCount;
      applyStimulus(vecs[i]);
      traceFrame(-1, 0, ok);
      if (ok) checkFrame($sformatf("vec%0d", i), vecs[i].effDiv, vecs[i].word,
                         vecs[i].parEn, vecs[i].expPar, vecs[i].expLen);
      repeat (4) @(negedge clk);
      checkOutput($sformatf("vec%0d_pops", i), rdCount - rd0, 1);
      checkOutput($sformatf("vec%0d_done_pulses", i), doneCount - done0, 1);
      checkOutput($sformatf("vec%0d_idle_busy", i), int'(busy), 0);
    end

    // Back-to-back frames: exactly two high cycles between stop and next start.
    rd0 = rdCount; done0 = doneCount;
    baudDiv = DIVW'(2); parityEn = 1'b0; stop2 = 1'b0;
    pushWord(8'hA5);
    pushWord(8'h3C);
    traceFrame(-1, 0, ok);
    if (ok) checkFrame("b2b_first", 2, 8'hA5, 1'b0, 1'b0, 20);
    prevDone = doneCyc;
    traceFrame(-1, 0, ok);
    checkOutput("b2b_gap_cycles", fallCyc - prevDone, 2);
    if (ok) checkFrame("b2b_second", 2, 8'h3C, 1'b0, 1'b0, 20);
    repeat (4) @(negedge clk);
    checkOutput("b2b_pops", rdCount - rd0, 2);
    checkOutput("b2b_done_pulses", doneCount - done0, 2);

    // Divisor change during DATA applies only to the following frame.
    baudDiv = DIVW'(3);
    pushWord(8'hFF);
    pushWord(8'h00);
    traceFrame(8, 8, ok);
    if (ok) checkFrame("divchg_first", 3, 8'hFF, 1'b0, 1'b0, 30);
    traceFrame(-1, 0, ok);
    if (ok) checkFrame("divchg_second", 8, 8'h00, 1'b0, 1'b0, 80);
    repeat (4) @(negedge clk);

    // One-cycle reset in the middle of DATA abandons the frame.
    baudDiv = DIVW'(4);
    pushWord(8'h55);
    pushWord(8'h33);
    waitFall(ok);
    repeat (6) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("midreset_txd", int'(txd), 1);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_tx_done", int'(txDone), 0);
    resetN = 1'b1;
    rd0 = rdCount;
    traceFrame(-1, 0, ok);
    if (ok) checkFrame("after_reset", 4, 8'h33, 1'b0, 1'b0, 40);
    repeat (4) @(negedge clk);
    checkOutput("after_reset_pops", rdCount - rd0, 1);

    checkOutput("pop_while_empty", rdWhileEmpty, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ms_uart_tx_engine.md
Name: ms_uart_tx_engine

Overview:
UART transmit engine that drains the TX FIFO, acting as its reader (RD/EMPTY/DOUT side), and serialises each word onto TXD. Frame format is programmable from the AHB-side control register: baud divisor, parity enable/odd, and 1 or 2 stop bits. Sits between the TX FIFO and the UART pin; status feeds the AHB status register.

Parameters:
DWIDTH, 8, data bits per frame; must match the FIFO word width.
DIVW, 16, width of the baud divisor.

Ports:
CLK  input  1  system clock; all logic on posedge.
RESETN  input  1  synchronous, active-low reset.
ENABLE  input  1  transmitter enable.
BAUD_DIV  input  DIVW  clocks per bit; a value of 0 is treated as 1.
PARITY_EN  input  1  append a parity bit.
PARITY_ODD  input  1  1 = odd parity, 0 = even.
STOP2  input  1  1 = two stop bits, 0 = one.
FIFO_EMPTY  input  1  FIFO empty flag.
FIFO_DOUT  input  DWIDTH  FIFO read data; valid the cycle after FIFO_RD.
FIFO_RD  output  1  registered one-cycle pop strobe.
TXD  output  1  serial line; idles high.
BUSY  output  1  high in every state except IDLE.
TX_DONE  output  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (RESETN low at posedge):
  - state = IDLE; TXD = 1; FIFO_RD = 0; BUSY = 0; TX_DONE = 0.
  - Bit counter and baud counter are cleared.
  - Reset takes effect mid-frame: the frame is abandoned and TXD returns high on the next edge. Any FIFO word already popped is lost.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - If ENABLE=1 and FIFO_EMPTY=0 at posedge -> FETCH. Otherwise stay in IDLE.
  - FIFO_EMPTY is sampled only at posedge.
- FETCH:
  - FIFO_RD = 1 for exactly this one cycle -> LOAD.
- LOAD:
  - Capture FIFO_DOUT into the shift register.
  - Latch BAUD_DIV, PARITY_EN, PARITY_ODD and STOP2. Changes to these inputs mid-frame are ignored.
  - Compute parity = XOR of the data bits, inverted when PARITY_ODD=1.
  - -> START.
- START: TXD = 0 for BAUD_DIV cycles -> DATA.
- DATA:
  - DWIDTH bits, LSB first, each held BAUD_DIV cycles.
  - After bit DWIDTH-1 -> PARITY if PARITY_EN=1, else STOP.
- PARITY: TXD = parity bit for BAUD_DIV cycles -> STOP.
- STOP:
  - TXD = 1 for BAUD_DIV cycles, or 2*BAUD_DIV cycles when STOP2=1.
  - At the end of STOP, TX_DONE pulses for one cycle (the first cycle of the next state).
  - Next state is FETCH if ENABLE=1 and FIFO_EMPTY=0, else IDLE.
- Latency: FIFO_EMPTY seen low at the end of IDLE cycle N -> FIFO_RD high in cycle N+1 -> TXD falls in cycle N+3.
- Frame length:
  - In TXD cycles: BAUD_DIV * (1 + DWIDTH + PARITY_EN + 1 + STOP2).
  - Back-to-back frames add exactly 2 extra high cycles (FETCH + LOAD) between stop bit and next start bit.
- ENABLE deasserted mid-frame: the current frame completes normally, and no further fetch occurs.
- FIFO_RD is never asserted while FIFO_EMPTY=1 was sampled. There is at most one pop per frame.
- Baud counter width is DIVW and counts down from BAUD_DIV-1 to 0. It has no wrap hazard.

Test Plan:
- Reset, FIFO_EMPTY=1, ENABLE=1 for 100 cycles -> FIFO_RD never asserts; TXD=1; BUSY=0.
- BAUD_DIV=4, no parity, 1 stop, FIFO word 0x55 -> FIFO_RD pulses once. Then TXD shows 0 (start) followed by 1,0,1,0,1,0,1,0, then 1 (stop), each held 4 cycles. That is 40 cycles from TXD fall to TX_DONE, with TX_DONE pulsing once.
- BAUD_DIV=2, PARITY_EN=1, word 0x07 -> parity bit 1 with even parity and 0 with odd. With STOP2=1 the frame is 24 cycles long.
- Two words 0xA5 then 0x3C queued -> two frames with exactly 2 high cycles between the stop bit and the next start bit; two FIFO_RD pulses; two TX_DONE pulses.
- Word 0xFF in flight at BAUD_DIV=3; change BAUD_DIV to 8 during DATA -> the frame keeps 3-cycle bits, and the next frame uses 8.
- RESETN low for 1 cycle during DATA of a frame -> TXD=1, BUSY=0, TX_DONE=0 next cycle. With FIFO_EMPTY=0 after release, the next word is fetched normally.
